// File: rtl/mips_multicycle.sv
// Multi-cycle MIPS-subset core: one shared req/ready memory port, FSM paced by a clock-enable tick.
// Optional feature: define MIPS_MC_ALIGN_CHECK_EN to halt on misaligned fetch or lw/sw addresses.
module mips_multicycle #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned TICK_DIV = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        halted,
    output logic [31:0] dbg_pc
);
    typedef enum logic [2:0] {
        StBoot, StFetch, StDecode, StExec, StMem, StWb, StHalt
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00, OpJ = 6'h02, OpBeq = 6'h04, OpBne = 6'h05;
    localparam logic [5:0] OpAddi = 6'h08, OpAddiu = 6'h09, OpSlti = 6'h0A, OpAndi = 6'h0C;
    localparam logic [5:0] OpOri = 6'h0D, OpLui = 6'h0F, OpLw = 6'h23, OpSw = 6'h2B;
    localparam logic [5:0] FnSll = 6'h00, FnSrl = 6'h02, FnAdd = 6'h20, FnAddu = 6'h21;
    localparam logic [5:0] FnSub = 6'h22, FnSubu = 6'h23, FnAnd = 6'h24, FnOr = 6'h25;
    localparam logic [5:0] FnSlt = 6'h2A;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic [31:0] res_q, res_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] rf_q [32];

    logic        tick;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu;
    logic        insn_ok;
    logic        fetch_misalign;
    logic        data_misalign;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm;
    logic [31:0] sext, zext;
    logic        is_ls, is_br, br_taken;

    assign opcode   = ir_q[31:26];
    assign rs       = ir_q[25:21];
    assign rt       = ir_q[20:16];
    assign rd       = ir_q[15:11];
    assign shamt    = ir_q[10:6];
    assign funct    = ir_q[5:0];
    assign imm      = ir_q[15:0];
    assign sext     = {{16{imm[15]}}, imm};
    assign zext     = {16'h0000, imm};
    assign is_ls    = (opcode == OpLw) || (opcode == OpSw);
    assign is_br    = (opcode == OpBeq) || (opcode == OpBne);
    assign br_taken = (opcode == OpBeq) ? (a_q == b_q) : (a_q != b_q);
    assign tick     = (cnt_q == TICK_DIV);
    assign cnt_d    = tick ? 32'd0 : cnt_q + 32'd1;

`ifdef MIPS_MC_ALIGN_CHECK_EN
    assign fetch_misalign = (pc_q[1:0] != 2'b00);
    assign data_misalign  = (alu[1:0] != 2'b00);
`else
    assign fetch_misalign = 1'b0;
    assign data_misalign  = 1'b0;
`endif

    always_comb begin
        insn_ok = 1'b0;
        case (opcode)
            OpRtype: insn_ok = funct inside {FnSll, FnSrl, FnAdd, FnAddu, FnSub, FnSubu,
                                             FnAnd, FnOr, FnSlt};
            OpJ, OpBeq, OpBne, OpAddi, OpAddiu, OpSlti, OpAndi, OpOri, OpLui, OpLw, OpSw:
                insn_ok = 1'b1;
            default: insn_ok = 1'b0;
        endcase
    end

    // add/sub never trap, so signed and unsigned variants share the adder.
    always_comb begin
        alu = 32'h0;
        if (opcode == OpRtype) begin
            case (funct)
                FnAdd, FnAddu: alu = a_q + b_q;
                FnSub, FnSubu: alu = a_q - b_q;
                FnAnd:         alu = a_q & b_q;
                FnOr:          alu = a_q | b_q;
                FnSlt:         alu = {31'h0, $signed(a_q) < $signed(b_q)};
                FnSll:         alu = b_q << shamt;
                FnSrl:         alu = b_q >> shamt;
                default:       alu = 32'h0;
            endcase
        end else begin
            case (opcode)
                OpAddi, OpAddiu, OpLw, OpSw: alu = a_q + sext;
                OpSlti:  alu = {31'h0, $signed(a_q) < $signed(sext)};
                OpAndi:  alu = a_q & zext;
                OpOri:   alu = a_q | zext;
                OpLui:   alu = {imm, 16'h0000};
                default: alu = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (tick) begin
            case (state_q)
                StBoot: state_d = StFetch;
                StFetch: begin
                    if (fetch_misalign) begin
                        state_d = StHalt;
                    end else if (mem_ready) begin
                        state_d = StDecode;
                    end
                end
                StDecode: state_d = insn_ok ? StExec : StHalt;
                StExec: begin
                    if (is_ls) begin
                        state_d = data_misalign ? StHalt : StMem;
                    end else if (is_br || (opcode == OpJ)) begin
                        state_d = StFetch;
                    end else begin
                        state_d = StWb;
                    end
                end
                StMem: begin
                    if (mem_ready) begin
                        state_d = (opcode == OpLw) ? StWb : StFetch;
                    end
                end
                StWb:    state_d = StFetch;
                StHalt:  state_d = StHalt;
                default: state_d = StHalt;
            endcase
        end
    end

    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = 32'h0;
        mem_wdata = 32'h0;
        case (state_q)
            StFetch: begin
                mem_req  = !fetch_misalign;
                mem_addr = pc_q;
            end
            StMem: begin
                mem_req  = 1'b1;
                mem_we   = (opcode == OpSw);
                mem_addr = res_q;
            end
            default: ;
        endcase
`ifndef MIPS_MC_ALIGN_CHECK_EN
        mem_addr[1:0] = 2'b00;
`endif
        if (mem_we) begin
            mem_wdata = b_q;
        end
        halted = (state_q == StHalt);
        dbg_pc = pc_q;
    end

    // res_q holds the ALU result / address and is reused as the load data register.
    always_comb begin
        pc_d     = pc_q;
        ir_d     = ir_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        tgt_d    = tgt_q;
        rf_we    = 1'b0;
        rf_waddr = 5'd0;
        if (tick) begin
            case (state_q)
                StFetch: begin
                    if (!fetch_misalign && mem_ready) begin
                        ir_d = mem_rdata;
                        pc_d = pc_q + 32'd4;
                    end
                end
                StDecode: begin
                    a_d   = rf_q[rs];
                    b_d   = rf_q[rt];
                    tgt_d = pc_q + {sext[29:0], 2'b00};
                end
                StExec: begin
                    res_d = alu;
                    if (is_br && br_taken) begin
                        pc_d = tgt_q;
                    end else if (opcode == OpJ) begin
                        pc_d = {pc_q[31:28], ir_q[25:0], 2'b00};
                    end
                end
                StMem: begin
                    if (mem_ready && (opcode == OpLw)) begin
                        res_d = mem_rdata;
                    end
                end
                StWb: begin
                    rf_we    = 1'b1;
                    rf_waddr = (opcode == OpRtype) ? rd : rt;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= 32'd0;
            pc_q  <= RESET_PC;
            ir_q  <= 32'h0;
            a_q   <= 32'h0;
            b_q   <= 32'h0;
            res_q <= 32'h0;
            tgt_q <= 32'h0;
        end else begin
            cnt_q <= cnt_d;
            pc_q  <= pc_d;
            ir_q  <= ir_d;
            a_q   <= a_d;
            b_q   <= b_d;
            res_q <= res_d;
            tgt_q <= tgt_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) begin
                rf_q[i] <= 32'h0;
            end
        end else if (rf_we && (rf_waddr != 5'd0)) begin
            rf_q[rf_waddr] <= res_q;
        end
    end
endmodule
